// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types, key-code constants, ALU op encodings and key
//                classification helpers for the keypad calculator sequencer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTER_A  = 3'd1,
        ST_OP_SET   = 3'd2,
        ST_ENTER_B  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_SHOW_RES = 3'd5,
        ST_ERROR    = 3'd6
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hE;
    localparam logic [3:0] KEY_DIV = 4'hF;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQU = 4'hD;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer_if
//  Description : Start/done handshake and operand/result bus between the
//                calculator sequencer (master) and the BCD ALU (slave).
//  Signals     : alu_start  launch pulse         (master -> slave)
//                alu_op     operation            (master -> slave)
//                opa, opb   BCD operands         (master -> slave)
//                alu_done   result valid         (slave -> master)
//                alu_result BCD magnitude        (slave -> master)
//                alu_neg    result negative      (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_sequencer_if #(
    parameter int DIGITS = 4
) ();
    logic                  alu_start;
    logic [1:0]            alu_op;
    logic [4*DIGITS-1:0]   opa;
    logic [4*DIGITS-1:0]   opb;
    logic                  alu_done;
    logic [4*DIGITS-1:0]   alu_result;
    logic                  alu_neg;

    modport master (
        output alu_start, alu_op, opa, opb,
        input  alu_done, alu_result, alu_neg
    );

    modport slave (
        input  alu_start, alu_op, opa, opb,
        output alu_done, alu_result, alu_neg
    );
endinterface
`default_nettype wire

// File: rtl/bcd_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry_reg
//  Description : BCD operand entry register: digits shift in from the right,
//                a counter caps entry at DIGITS, leading zeros are not counted.
//  Ports       : clk, resetn       clock, async active-low reset
//                clear             zero value and count (combines with shift)
//                shift, digit      shift digit in
//                load, load_val    load a whole value (count saturated)
//                value             registered operand
//                value_nxt         value that the next edge will register
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_entry_reg #(
    parameter int DIGITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    input  wire logic                  clear,
    input  wire logic                  shift,
    input  wire logic [3:0]            digit,
    input  wire logic                  load,
    input  wire logic [4*DIGITS-1:0]   load_val,
    output logic      [4*DIGITS-1:0]   value,
    output logic      [4*DIGITS-1:0]   value_nxt
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [4*DIGITS-1:0] r_value;
    logic [CW-1:0]       r_count;
    logic [4*DIGITS-1:0] w_base_v;
    logic [CW-1:0]       w_base_c;
    logic [CW-1:0]       w_count_nxt;

    // Clear acts first so that "clear + shift" loads a fresh single digit.
    always_comb begin
        w_base_v    = clear ? '0 : r_value;
        w_base_c    = clear ? '0 : r_count;
        value_nxt   = w_base_v;
        w_count_nxt = w_base_c;
        if (load) begin
            value_nxt   = load_val;
            w_count_nxt = CW'(DIGITS);
        end else if (shift && (w_base_c != CW'(DIGITS)) &&
                     !((w_base_c == '0) && (digit == 4'd0))) begin
            value_nxt   = {w_base_v[4*DIGITS-5:0], digit};
            w_count_nxt = w_base_c + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= value_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Keypad calculator controller: operand entry, operator latch,
//                ALU start/done handshake with timeout, display selection.
//  Ports       : clk, resetn             clock, async active-low reset
//                key_valid, key_code     decoded key event
//                alu                     ALU handshake bus (master side)
//                disp_bcd, disp_neg      display value and minus sign
//                error                   high in ERROR state
//                state_dbg               current state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ALU_TIMEOUT = 15
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    input  wire logic                  key_valid,
    input  wire logic [3:0]            key_code,
    calc_sequencer_if.master           alu,
    output logic      [4*DIGITS-1:0]   disp_bcd,
    output logic                       disp_neg,
    output logic                       error,
    output logic      [2:0]            state_dbg
);
    localparam int W  = 4 * DIGITS;
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_op, w_op_nxt;
    logic [W-1:0]    r_result, w_result_nxt;
    logic            r_result_neg, w_result_neg_nxt;
    logic [TW-1:0]   r_tcnt;
    logic            r_alu_start;
    logic [W-1:0]    r_disp, w_disp_nxt;
    logic            r_disp_neg;
    logic            r_error;

    logic            w_a_clear, w_a_shift, w_a_load, w_b_clear, w_b_shift;
    logic [W-1:0]    w_opa, w_opa_nxt, w_opb, w_opb_nxt;

    logic            w_key_digit, w_key_op, w_key_clr, w_key_equ, w_done_take;

    assign w_key_digit = key_valid && is_digit(key_code);
    assign w_key_op    = key_valid && is_op(key_code);
    assign w_key_clr   = key_valid && (key_code == KEY_CLR);
    assign w_key_equ   = key_valid && (key_code == KEY_EQU);
    // Clear beats a simultaneous done: the result is dropped.
    assign w_done_take = (r_state == ST_EXEC) && alu.alu_done && !w_key_clr;

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_a (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (w_a_clear),
        .shift     (w_a_shift),
        .digit     (key_code),
        .load      (w_a_load),
        .load_val  (r_result),
        .value     (w_opa),
        .value_nxt (w_opa_nxt)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_b (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (w_b_clear),
        .shift     (w_b_shift),
        .digit     (key_code),
        .load      (1'b0),
        .load_val  ('0),
        .value     (w_opb),
        .value_nxt (w_opb_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_a_clear   = 1'b0;
        w_a_shift   = 1'b0;
        w_a_load    = 1'b0;
        w_b_clear   = 1'b0;
        w_b_shift   = 1'b0;
        if (w_key_clr) begin
            w_state_nxt = ST_IDLE;
            w_op_nxt    = OP_ADD;
            w_a_clear   = 1'b1;
            w_b_clear   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key_digit) begin
                        w_state_nxt = ST_ENTER_A;
                        w_a_clear   = 1'b1;
                        w_a_shift   = 1'b1;
                    end else if (w_key_op) begin
                        w_state_nxt = ST_OP_SET;
                        w_a_clear   = 1'b1;
                        w_op_nxt    = key_to_op(key_code);
                    end
                end
                ST_ENTER_A: begin
                    if (w_key_digit) begin
                        w_a_shift = 1'b1;
                    end else if (w_key_op) begin
                        w_state_nxt = ST_OP_SET;
                        w_op_nxt    = key_to_op(key_code);
                    end
                end
                ST_OP_SET: begin
                    if (w_key_op) begin
                        w_op_nxt = key_to_op(key_code);
                    end else if (w_key_digit) begin
                        w_state_nxt = ST_ENTER_B;
                        w_b_clear   = 1'b1;
                        w_b_shift   = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    if (w_key_digit) begin
                        w_b_shift = 1'b1;
                    end else if (w_key_equ) begin
                        w_state_nxt = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (alu.alu_done) begin
                        w_state_nxt = ST_SHOW_RES;
                    end else if (r_tcnt == TW'(ALU_TIMEOUT - 1)) begin
                        w_state_nxt = ST_ERROR;
                    end
                end
                ST_SHOW_RES: begin
                    if (w_key_digit) begin
                        w_state_nxt = ST_ENTER_A;
                        w_a_clear   = 1'b1;
                        w_a_shift   = 1'b1;
                        w_b_clear   = 1'b1;
                    end else if (w_key_op && !r_result_neg) begin
                        // Chain the magnitude into the next calculation.
                        w_state_nxt = ST_OP_SET;
                        w_a_load    = 1'b1;
                        w_b_clear   = 1'b1;
                        w_op_nxt    = key_to_op(key_code);
                    end
                end
                ST_ERROR: begin
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_result_nxt     = r_result;
        w_result_neg_nxt = r_result_neg;
        if (w_key_clr) begin
            w_result_nxt     = '0;
            w_result_neg_nxt = 1'b0;
        end else if (w_done_take) begin
            w_result_nxt     = alu.alu_result;
            w_result_neg_nxt = alu.alu_neg;
        end
    end

    // Display is computed from next-state values so it is registered yet
    // still tracks a key on the very next cycle.
    always_comb begin
        w_disp_nxt = '0;
        case (w_state_nxt)
            ST_ENTER_A, ST_OP_SET: w_disp_nxt = w_opa_nxt;
            ST_ENTER_B, ST_EXEC:   w_disp_nxt = w_opb_nxt;
            ST_SHOW_RES:           w_disp_nxt = w_result_nxt;
            default:               w_disp_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_ADD;
            r_result     <= '0;
            r_result_neg <= 1'b0;
            r_tcnt       <= '0;
            r_alu_start  <= 1'b0;
            r_disp       <= '0;
            r_disp_neg   <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_result     <= w_result_nxt;
            r_result_neg <= w_result_neg_nxt;
            r_tcnt       <= ((r_state == ST_EXEC) && (w_state_nxt == ST_EXEC)) ?
                            r_tcnt + TW'(1) : '0;
            r_alu_start  <= (w_state_nxt == ST_EXEC) && (r_state != ST_EXEC);
            r_disp       <= w_disp_nxt;
            r_disp_neg   <= (w_state_nxt == ST_SHOW_RES) && w_result_neg_nxt;
            r_error      <= (w_state_nxt == ST_ERROR);
        end
    end

    assign alu.alu_start = r_alu_start;
    assign alu.alu_op    = r_op;
    assign alu.opa       = w_opa;
    assign alu.opb       = w_opb;
    assign disp_bcd      = r_disp;
    assign disp_neg      = r_disp_neg;
    assign error         = r_error;
    assign state_dbg     = r_state;

endmodule
`default_nettype wire
